// File: rtl/lsu_byte_ctrl.sv
// rtl/lsu_byte_ctrl.sv - byte-serial load/store initiator between execute stage and byte-wide data memory
module lsu_byte_ctrl #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  idx;
    logic [1:0]  last_idx;
    logic [31:0] asm_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [1:0]  last_req;
    logic        legal_f3;
    logic [32:0] end_addr;
    logic        in_range;
    logic [31:0] asm_next;
    logic [31:0] rdata_next;
    logic [7:0]  wbyte;
    logic        in_xfer;

    always_comb begin
        case (func3[1:0])
            2'b00:   last_req = 2'd0;
            2'b01:   last_req = 2'd1;
            default: last_req = 2'd3;
        endcase
    end

    always_comb begin
        legal_f3 = 1'b0;
        if (we)
            legal_f3 = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010);
        else
            legal_f3 = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b010) ||
                       (func3 == 3'b100) || (func3 == 3'b101);
    end

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign end_addr = {1'b0, addr} + {31'b0, last_req};
    assign in_range = end_addr <= 33'(MEM_BYTES - 1);

    // Assembly including the byte arriving this cycle, so the final byte reaches rdata on the same edge
    always_comb begin
        asm_next = asm_q;
        if (!we_q) begin
            case (idx)
                2'd0: asm_next[7:0]   = mem_rdata;
                2'd1: asm_next[15:8]  = mem_rdata;
                2'd2: asm_next[23:16] = mem_rdata;
                default: asm_next[31:24] = mem_rdata;
            endcase
        end
    end

    always_comb begin
        rdata_next = 32'h0;
        if (!we_q) begin
            case (f3_q)
                3'b000:  rdata_next = {{24{asm_next[7]}}, asm_next[7:0]};
                3'b001:  rdata_next = {{16{asm_next[15]}}, asm_next[15:0]};
                3'b010:  rdata_next = asm_next;
                3'b100:  rdata_next = {24'h0, asm_next[7:0]};
                3'b101:  rdata_next = {16'h0, asm_next[15:0]};
                default: rdata_next = 32'h0;
            endcase
        end
    end

    always_comb begin
        case (idx)
            2'd0:    wbyte = wdata_q[7:0];
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            default: wbyte = wdata_q[31:24];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            idx      <= 2'd0;
            last_idx <= 2'd0;
            asm_q    <= 32'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        f3_q     <= func3;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        idx      <= 2'd0;
                        last_idx <= last_req;
                        asm_q    <= 32'h0;
                        if (legal_f3 && in_range) begin
                            state <= S_XFER;
                            err_q <= 1'b0;
                        end else begin
                            state   <= S_DONE;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                S_XFER: begin
                    idx   <= idx + 2'd1;
                    asm_q <= asm_next;
                    if (idx == last_idx) begin
                        state   <= S_DONE;
                        rdata_q <= rdata_next;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are squashed while rst is high so an abandoned transfer writes nothing on the reset edge
    assign in_xfer   = (state == S_XFER);
    assign mem_re    = in_xfer & ~we_q & ~rst;
    assign mem_we    = in_xfer & we_q & ~rst;
    assign mem_addr  = in_xfer ? (addr_q + {30'b0, idx}) : 32'h0;
    assign mem_wdata = in_xfer ? wbyte : 8'h00;

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign err   = done & err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_lsu_byte_ctrl.sv
// tb/tb_lsu_byte_ctrl.sv - directed self-checking bench for lsu_byte_ctrl
module tb_lsu_byte_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:4095];
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'h0;
    logic [7:0]  pre_data = 8'h0;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    bit both_bad = 0;
    bit busy_bad = 0;
    logic [39:0] wlog [$];

    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          nstb;
    logic [8:0]  busy_pat, we_pat, done_pat;

    lsu_byte_ctrl #(.MEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .func3(func3), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd4096) ? mem[mem_addr[11:0]] : 8'h00;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_we && mem_addr < 32'd4096)
            mem[mem_addr[11:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_re || mem_we) strobe_cnt++;
        if (mem_re && mem_we) both_bad = 1;
        if (mem_we) wlog.push_back({mem_addr, mem_wdata});
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d);
        int s0;
        bit seen;
        @(negedge clk);
        req = 1'b1; we = w; func3 = f; addr = a; wdata = d;
        s0 = strobe_cnt;
        @(posedge clk);
        #1 req = 1'b0;
        cyc = 0; seen = 0; rd = 32'hDEAD_BEEF; er = 1'bx;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1; rd = rdata; er = err;
            end else if (!busy) begin
                busy_bad = 1;
            end
        end
        if (!seen) check("timeout", 40'd0, 40'd1);
        nstb = strobe_cnt - s0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ctl", {35'd0, busy, done, err, mem_re, mem_we}, 40'd0);
        check("rst_rdata", {8'd0, rdata}, 40'd0);
        check("rst_maddr", {8'd0, mem_addr}, 40'd0);
        check("rst_wdata", {32'd0, mem_wdata}, 40'd0);
        rst = 1'b0;

        wlog.delete();
        do_req(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4);
        check("sw_cyc", cyc, 5);
        check("sw_err", {39'd0, er}, 40'd0);
        check("sw_rdata", {8'd0, rd}, 40'd0);
        check("sw_nlog", wlog.size(), 4);
        if (wlog.size() == 4) begin
            check("sw_b0", wlog[0], {32'h10, 8'hD4});
            check("sw_b1", wlog[1], {32'h11, 8'hC3});
            check("sw_b2", wlog[2], {32'h12, 8'hB2});
            check("sw_b3", wlog[3], {32'h13, 8'hA1});
        end

        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        check("lw_cyc", cyc, 5);
        check("lw_nstb", nstb, 4);
        check("lw_rdata", {8'd0, rd}, {8'd0, 32'hA1B2C3D4});

        poke(12'h020, 8'h80);
        poke(12'h021, 8'hFF);
        do_req(1'b0, 3'b000, 32'h20, 32'h0);
        check("lb", {8'd0, rd}, {8'd0, 32'hFFFFFF80});
        check("lb_cyc", cyc, 2);
        do_req(1'b0, 3'b100, 32'h20, 32'h0);
        check("lbu", {8'd0, rd}, {8'd0, 32'h00000080});
        do_req(1'b0, 3'b001, 32'h20, 32'h0);
        check("lh", {8'd0, rd}, {8'd0, 32'hFFFFFF80});
        check("lh_cyc", cyc, 3);
        do_req(1'b0, 3'b101, 32'h20, 32'h0);
        check("lhu", {8'd0, rd}, {8'd0, 32'h0000FF80});

        poke(12'hFFC, 8'h01);
        poke(12'hFFD, 8'h02);
        poke(12'hFFE, 8'h03);
        poke(12'hFFF, 8'h04);
        do_req(1'b0, 3'b010, 32'hFFC, 32'h0);
        check("lw_top_err", {39'd0, er}, 40'd0);
        check("lw_top", {8'd0, rd}, {8'd0, 32'h04030201});

        do_req(1'b0, 3'b010, 32'hFFD, 32'h0);
        check("lw_ovf_err", {39'd0, er}, 40'd1);
        check("lw_ovf_cyc", cyc, 1);
        check("lw_ovf_nstb", nstb, 0);
        check("lw_ovf_rdata", {8'd0, rd}, 40'd0);

        do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
        check("lh_wrap_err", {39'd0, er}, 40'd1);
        check("lh_wrap_nstb", nstb, 0);

        do_req(1'b0, 3'b011, 32'h0, 32'h0);
        check("ld_f3_err", {39'd0, er}, 40'd1);

        poke(12'h060, 8'h77);
        do_req(1'b1, 3'b100, 32'h60, 32'h12345678);
        check("st_f3_err", {39'd0, er}, 40'd1);
        check("st_f3_nstb", nstb, 0);
        check("st_f3_mem", {32'd0, mem[12'h060]}, {32'd0, 8'h77});

        poke(12'h040, 8'hEE);
        poke(12'h041, 8'hEE);
        @(negedge clk);
        req = 1'b1; we = 1'b1; func3 = 3'b010; addr = 32'h40; wdata = 32'h11223344;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ctl", {35'd0, busy, done, err, mem_re, mem_we}, 40'd0);
        check("abort_rdata", {8'd0, rdata}, 40'd0);
        check("abort_maddr", {8'd0, mem_addr}, 40'd0);
        check("abort_wdata", {32'd0, mem_wdata}, 40'd0);
        rst = 1'b0;
        check("abort_b0", {32'd0, mem[12'h040]}, {32'd0, 8'h44});
        check("abort_b1", {32'd0, mem[12'h041]}, {32'd0, 8'hEE});
        do_req(1'b0, 3'b000, 32'h40, 32'h0);
        check("abort_lb", {8'd0, rd}, {8'd0, 32'h00000044});
        check("abort_lb_err", {39'd0, er}, 40'd0);

        @(negedge clk);
        req = 1'b1; we = 1'b1; func3 = 3'b000; addr = 32'h50; wdata = 32'h0000005A;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            busy_pat[i] = busy;
            we_pat[i]   = mem_we;
            done_pat[i] = done;
        end
        req = 1'b0;
        check("b2b_busy", {31'd0, busy_pat}, {31'd0, 9'b011011011});
        check("b2b_we", {31'd0, we_pat}, {31'd0, 9'b001001001});
        check("b2b_done", {31'd0, done_pat}, {31'd0, 9'b010010010});
        repeat (3) @(negedge clk);
        check("b2b_idle", {39'd0, busy}, 40'd0);
        check("b2b_mem", {32'd0, mem[12'h050]}, {32'd0, 8'h5A});

        check("never_both", {39'd0, both_bad}, 40'd0);
        check("busy_hold", {39'd0, busy_bad}, 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_byte_ctrl.md
Name: lsu_byte_ctrl

Overview:
- Load/store initiator that sits between the execute stage and the byte-wide data memory port.
- Accepts one word/half/byte load or store request from the pipeline and serialises it into single-byte memory accesses, one byte per cycle, in little-endian order.
- For loads, assembles the returned bytes and applies sign or zero extension per func3.
- Flags illegal func3 codes and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 4096, size of the data memory in bytes; valid byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  1  request strobe from the pipeline; sampled only when busy=0.
- we  in  1  1=store, 0=load; sampled with req.
- func3  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW); sampled with req.
- addr  in  32  byte address of the first byte; sampled with req.
- wdata  in  32  store data; sampled with req.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = request rejected.
- rdata  out  32  extended load result; valid while done=1, held until the next done.
- mem_addr  out  32  byte address to memory.
- mem_re  out  1  byte read strobe.
- mem_we  out  1  byte write strobe; memory writes on the rising edge.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read from memory, valid combinationally in the same cycle as mem_re.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE; busy=0, done=0, err=0, rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Any transfer in progress is abandoned. No further strobes are issued after the reset edge; bytes already written stay written.
- States: IDLE, XFER, DONE.
- IDLE:
  - With req=1, latch we, func3, addr, wdata; clear byte index idx=0.
  - Byte count n = 1, 2 or 4 for func3[1:0] = 00, 01, 10 respectively.
  - Legal loads: 000, 001, 010, 100, 101. Legal stores: 000, 001, 010.
  - Legal request with addr+n-1 <= MEM_BYTES-1 (compare in 33-bit arithmetic so 32-bit wrap is caught): go to XFER.
  - Otherwise (illegal func3 or range overflow): go to DONE with err=1; no memory strobe is ever asserted.
- XFER:
  - Issue exactly one strobe per cycle: mem_re=~we, mem_we=we.
  - mem_addr = addr_q+idx; mem_wdata = wdata_q[8*idx+7:8*idx].
  - On loads, capture mem_rdata into assembly byte lane idx at the cycle-end edge.
  - idx increments each cycle. After the strobe with idx=n-1, go to DONE.
- DONE:
  - Exactly one cycle: done=1; err as decided in IDLE; strobes 0; then return to IDLE.
  - rdata is registered and updates on the edge entering DONE:
    - LB: sign-extend byte 0. LH: sign-extend bytes 1:0.
    - LBU/LHU: zero-extend. LW: bytes 3..0 as assembled.
    - Store or err: rdata=0.
- Latency from the req-sampling edge: XFER occupies n cycles, done is asserted in the cycle after that. Total n+1 cycles; an erroneous request takes 1 cycle.
- A new req can be accepted in the cycle after done (IDLE). req while busy=1 is ignored, not queued.
- A request ending exactly at MEM_BYTES-1 is legal. One byte beyond it is err.
- Memory ports are never driven outside XFER, and mem_re and mem_we are never high together.

Test Plan:
- SW addr=0x10 wdata=0xA1B2C3D4 -> 4 consecutive mem_we cycles at 0x10..0x13 with bytes D4,C3,B2,A1; done on cycle 5, err=0.
- LW addr=0x10 after the store above -> 4 mem_re cycles; rdata=0xA1B2C3D4 with done on cycle 5.
- Memory bytes 0x20=0x80, 0x21=0xFF:
  - LB 0x20 -> 0xFFFFFF80.
  - LBU 0x20 -> 0x00000080.
  - LH 0x20 -> 0xFFFFFF80.
  - LHU 0x20 -> 0x0000FF80.
- With MEM_BYTES=4096:
  - LW addr=0xFFC -> legal, err=0.
  - LW addr=0xFFD -> done+err next cycle, no strobes.
  - LH addr=0xFFFFFFFF -> err.
  - Store func3=100 -> err, memory untouched.
- rst asserted at idx=1 of an SW to 0x40 -> IDLE next cycle with all outputs 0; only byte 0x40 is modified; a subsequent LB 0x40 completes normally.
- req held high continuously with back-to-back SB requests -> second request accepted only in the cycle after done; busy high throughout each transfer; mem_re and mem_we never both high.
